// File: rtl/truth_table_scanner.sv
// Exhaustive scanner for a 5-input combinational function: drives all 32 vectors,
// captures the response table and compares it with a golden table.
module truth_table_scanner #(
  parameter int HOLD_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] expected,
  input  logic        y_in,
  output logic [4:0]  x_out,
  output logic        busy,
  output logic        done,
  output logic [31:0] table_out,
  output logic [5:0]  ones_count,
  output logic [5:0]  err_count,
  output logic [4:0]  first_err,
  output logic        pass
);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  state_t     state, state_nxt;
  logic [3:0] hold_cnt;
  logic       hold_last, mism, accept;
  logic [5:0] err_nxt;

  assign hold_last = (hold_cnt == 4'(HOLD_CYCLES - 1));
  assign mism      = y_in ^ expected[x_out];
  assign err_nxt   = err_count + {5'd0, mism};
  assign accept    = start && !abort;

  // Status is decoded from state so an async reset clears it immediately.
  assign busy = (state == DRIVE) || (state == SAMPLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = DRIVE;
      DRIVE:   if (abort) state_nxt = IDLE;
               else if (hold_last) state_nxt = SAMPLE;
      SAMPLE:  if (abort) state_nxt = IDLE;
               else if (x_out == 5'd31) state_nxt = DONE;
               else state_nxt = DRIVE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_out      <= '0;
      hold_cnt   <= '0;
      table_out  <= '0;
      ones_count <= '0;
      err_count  <= '0;
      first_err  <= '0;
      pass       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          x_out      <= '0;
          hold_cnt   <= '0;
          table_out  <= '0;
          ones_count <= '0;
          err_count  <= '0;
          first_err  <= '0;
          pass       <= 1'b0;
        end
        DRIVE: if (!abort) hold_cnt <= hold_last ? 4'd0 : hold_cnt + 4'd1;
        // An abort during SAMPLE drops the in-flight sample entirely.
        SAMPLE: if (!abort) begin
          table_out[x_out] <= y_in;
          ones_count       <= ones_count + {5'd0, y_in};
          err_count        <= err_nxt;
          if (mism && err_count == 6'd0) first_err <= x_out;
          if (x_out == 5'd31) pass <= (err_nxt == 6'd0);
          else                x_out <= x_out + 5'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/truth_table_scanner.md
TRUTH_TABLE_SCANNER -- requirements
Module: truth_table_scanner

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 2, settle cycles per input vector before sampling (legal range 1..15).
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port start, input, 1, request a full 32-vector scan.
REQ-005 SHALL have port abort, input, 1, cancel scan in progress.
REQ-006 SHALL have port expected, input, 32, golden truth table; bit i is expected y for x=i.
REQ-007 SHALL have port y_in, input, 1, response of the 5-input function under test.
REQ-008 SHALL have port x_out, output, 5, input vector driven to the function under test.
REQ-009 SHALL have port busy, output, 1, high while a scan is running.
REQ-010 SHALL have port done, output, 1, one-cycle pulse on scan completion.
REQ-011 SHALL have port table_out, output, 32, captured truth table; bit i holds y for x=i.
REQ-012 SHALL have port ones_count, output, 6, number of captured 1s (0..32).
REQ-013 SHALL have port err_count, output, 6, number of bits where captured differs from expected (0..32).
REQ-014 SHALL have port first_err, output, 5, lowest index with a mismatch; valid only when err_count nonzero.
REQ-015 SHALL have port pass, output, 1, high when the last completed scan had err_count 0.

Function
REQ-016 SHALL implement FSM states IDLE, DRIVE, SAMPLE, DONE.
REQ-017 IDLE: start=1 and abort=0 at an edge SHALL move to DRIVE, set x_out=0 and hold counter=0, and clear table_out, ones_count, err_count, first_err, pass.
REQ-018 DRIVE SHALL last exactly HOLD_CYCLES cycles with x_out stable, then go to SAMPLE.
REQ-019 SAMPLE SHALL last one cycle; at its closing edge table_out[x_out] SHALL be set to y_in and ones_count SHALL add y_in.
REQ-020 At that same edge, if y_in differs from expected[x_out], err_count SHALL increment, and first_err SHALL be set to x_out if err_count was 0.
REQ-021 After SAMPLE with x_out below 31: x_out SHALL increment and the FSM SHALL return to DRIVE.
REQ-022 After SAMPLE with x_out equal to 31: the FSM SHALL go to DONE; x_out SHALL remain 31 and SHALL NOT wrap.
REQ-023 DONE SHALL last one cycle with done=1 and busy=0; pass SHALL be set to (err_count==0) at the DONE entry edge; the FSM SHALL then return to IDLE.
REQ-024 busy SHALL equal 1 exactly in DRIVE and SAMPLE.
REQ-025 Scan latency: the done cycle SHALL begin 32*(HOLD_CYCLES+1) cycles after the start-accept edge (96 for the default).
REQ-026 start SHALL be ignored in DRIVE, SAMPLE and DONE.
REQ-027 abort=1 in DRIVE or SAMPLE SHALL force IDLE at the next edge.
REQ-028 On abort, the in-flight sample SHALL be discarded, done SHALL NOT pulse, pass SHALL be 0, and partial table_out and counts SHALL be retained.
REQ-029 start and abort both high in IDLE: abort SHALL win and the FSM SHALL stay IDLE.
REQ-030 ones_count and err_count SHALL be 6 bits wide and SHALL reach 32 without overflow.
REQ-031 All results SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-032 rst_n low SHALL immediately force the state to IDLE, independent of clk.
REQ-033 rst_n low SHALL immediately set x_out=0, busy=0, done=0, table_out=0, ones_count=0, err_count=0, first_err=0, pass=0 and hold counter=0.
REQ-034 Reset asserted mid-scan SHALL abandon the scan without a done pulse; the first accepted start after release SHALL begin at x_out=0.

Verification
REQ-035 Scenario: y_in = x_out[0], expected=32'hAAAA_AAAA, pulse start -> done exactly 96 cycles later; table_out=32'hAAAA_AAAA, ones_count=16, err_count=0, pass=1.
REQ-036 Scenario: same stimulus with expected=32'hAAAA_AAAB -> err_count=1, first_err=0, pass=0.
REQ-037 Scenario: y_in tied 1, expected=0 -> ones_count=32, err_count=32, first_err=0, pass=0.
REQ-038 Scenario: abort asserted 40 cycles after start -> busy=0 next cycle, no done pulse, pass=0; a new start then completes normally.
REQ-039 Scenario: start re-pulsed while busy, plus start and abort together in IDLE -> scan timing unchanged, and no scan started, respectively.
REQ-040 Scenario: rst_n dropped mid-scan between clock edges -> all outputs 0 before the next edge, and no done pulse.
